// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter: FSM states,
// port indices, the word access mode and the per-port command builder.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } arb_state_t;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  localparam logic [2:0] MODE_WORD = 3'd2;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  mode;
  } mem_cmd_t;

  // The instruction port is read-only and always fetches whole words.
  function automatic mem_cmd_t port_cmd(
    input logic        port,
    input logic [31:0] i_addr,
    input logic        d_we,
    input logic [31:0] d_addr,
    input logic [31:0] d_wdata,
    input logic [2:0]  d_mode
  );
    mem_cmd_t cmd;
    if (port == PORT_I) begin
      cmd.we    = 1'b0;
      cmd.addr  = i_addr;
      cmd.wdata = '0;
      cmd.mode  = MODE_WORD;
    end else begin
      cmd.we    = d_we;
      cmd.addr  = d_addr;
      cmd.wdata = d_wdata;
      cmd.mode  = d_mode;
    end
    return cmd;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of requester-side and memory-side signals of the arbiter.
// slave is the arbiter's view; master is the view of the requesters plus memory.
interface mem_arbiter_if;

  logic        i_req;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_done;

  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [2:0]  d_mode;
  logic [31:0] d_rdata;
  logic        d_done;

  logic        err;

  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [2:0]  mem_mode;
  logic        mem_read_en;
  logic        mem_write_en;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_mode, mem_rdata, mem_ack,
    output i_rdata, i_done, d_rdata, d_done, err,
           mem_addr, mem_wdata, mem_mode, mem_read_en, mem_write_en
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_mode, mem_rdata, mem_ack,
    input  i_rdata, i_done, d_rdata, d_done, err,
           mem_addr, mem_wdata, mem_mode, mem_read_en, mem_write_en
  );

endinterface

// File: rtl/mem_arbiter_rr_pick2.sv
// Combinational two-way round-robin picker; holds no state of its own.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  // A lone requester always wins; on a tie the port not granted last wins.
  for (genvar gi = 0; gi < 2; gi++) begin : g_pick
    assign gnt[gi] = req[gi] && (!req[1 - gi] || (last != 1'(gi)));
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (instruction/data) arbiter in front of a single DataMemory port.
// One access at a time: IDLE arbitrates, BUSY waits for ack or timeout, RESP pulses done.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT = 15
) (
  input logic          clk,
  input logic          reset,
  mem_arbiter_if.slave bus
);

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  arb_state_t  state_reg;
  logic        last_grant_reg;
  logic        active_port_reg;
  logic [7:0]  count_reg;
  logic [1:0]  done_reg;
  logic [31:0] rdata_reg [2];

  logic [1:0]  req_vec;
  logic [1:0]  gnt_vec;
  logic        win_port;
  mem_cmd_t    win_cmd;
  logic [31:0] resp_data;

  assign req_vec = {bus.d_req, bus.i_req};

  rr_pick2 u_pick (
    .req  (req_vec),
    .last (last_grant_reg),
    .gnt  (gnt_vec)
  );

  assign win_port = gnt_vec[PORT_D];
  assign win_cmd  = port_cmd(win_port, bus.i_addr, bus.d_we, bus.d_addr, bus.d_wdata, bus.d_mode);

  // Only an acknowledged read returns data; writes and timeouts report zero.
  assign resp_data = (bus.mem_ack && bus.mem_read_en) ? bus.mem_rdata : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg        <= ST_IDLE;
      last_grant_reg   <= PORT_D;
      active_port_reg  <= PORT_I;
      count_reg        <= '0;
      done_reg         <= '0;
      rdata_reg[PORT_I] <= '0;
      rdata_reg[PORT_D] <= '0;
      bus.err          <= 1'b0;
      bus.mem_addr     <= '0;
      bus.mem_wdata    <= '0;
      bus.mem_mode     <= MODE_WORD;
      bus.mem_read_en  <= 1'b0;
      bus.mem_write_en <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (|gnt_vec) begin
            state_reg        <= ST_BUSY;
            last_grant_reg   <= win_port;
            active_port_reg  <= win_port;
            count_reg        <= '0;
            bus.mem_addr     <= win_cmd.addr;
            bus.mem_wdata    <= win_cmd.wdata;
            bus.mem_mode     <= win_cmd.mode;
            bus.mem_read_en  <= !win_cmd.we;
            bus.mem_write_en <= win_cmd.we;
          end
        end

        ST_BUSY: begin
          // Ack takes priority over a timeout that expires in the same cycle.
          if (bus.mem_ack || (count_reg == TIMEOUT_CNT)) begin
            state_reg                  <= ST_RESP;
            bus.mem_read_en            <= 1'b0;
            bus.mem_write_en           <= 1'b0;
            bus.err                    <= !bus.mem_ack;
            done_reg[active_port_reg]  <= 1'b1;
            rdata_reg[active_port_reg] <= resp_data;
          end else begin
            count_reg <= count_reg + 8'd1;
          end
        end

        ST_RESP: begin
          state_reg <= ST_IDLE;
          done_reg  <= '0;
          bus.err   <= 1'b0;
        end

        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.i_done  = done_reg[PORT_I];
  assign bus.d_done  = done_reg[PORT_D];
  assign bus.i_rdata = rdata_reg[PORT_I];
  assign bus.d_rdata = rdata_reg[PORT_D];

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 15, max BUSY cycles waiting for mem_ack before abort (1..255).
REQ-002 clk  input  1  system clock, all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 i_req  input  1  instruction-side (port 0) request, held until i_done.
REQ-005 i_addr  input  32  port 0 byte address; port 0 is read-only.
REQ-006 i_rdata  output  32  port 0 read data, valid while i_done=1.
REQ-007 i_done  output  1  port 0 completion pulse, one cycle.
REQ-008 d_req  input  1  data-side (port 1) request, held until d_done.
REQ-009 d_we  input  1  port 1 write (1) or read (0).
REQ-010 d_addr, d_wdata  input  32 each  port 1 address and write data.
REQ-011 d_mode  input  3  port 1 access mode (1=byte, 2=word), passed through to memory.
REQ-012 d_rdata  output  32  port 1 read data, valid while d_done=1.
REQ-013 d_done  output  1  port 1 completion pulse, one cycle.
REQ-014 err  output  1  asserted with the done pulse when the access timed out.
REQ-015 mem_addr, mem_wdata  output  32 each  registered address and write data to DataMemory.
REQ-016 mem_mode  output  3  registered mode; port 0 accesses always use mode 2.
REQ-017 mem_read_en, mem_write_en  output  1 each  registered memory strobes.
REQ-018 mem_rdata  input  32  memory read data, sampled when mem_ack=1.
REQ-019 mem_ack  input  1  memory completion, any latency of 0 or more BUSY cycles.

Function
REQ-020 FSM states: IDLE, BUSY, RESP; encoding defined in a shared package.
REQ-021 IDLE, no request: stay in IDLE with all strobes 0.
REQ-022 IDLE, any request: go to BUSY. Register the winner's payload onto mem_*. Set exactly one of mem_read_en/mem_write_en.
REQ-023 Arbitration: a single requester wins. On a tie, the port not granted last wins. last_grant resets to 1, so port 0 wins the first tie.
REQ-024 BUSY: mem_* outputs are held stable. On mem_ack=1, capture mem_rdata (reads) and go to RESP.
REQ-025 BUSY timeout counter:
- cleared on entry to BUSY;
- increments each BUSY cycle without ack;
- on reaching TIMEOUT without ack: go to RESP with err=1 and rdata=0.
REQ-026 mem_ack and timeout in the same cycle: ack wins, err=0.
REQ-027 RESP (exactly one cycle):
- strobes 0;
- the granted port's done=1 with rdata;
- err as set in BUSY;
- then go to IDLE.
REQ-028 Requesters drop req on the edge that ends the done cycle. Requests arriving during BUSY/RESP wait for IDLE; there is no queueing beyond req hold.
REQ-029 Latency: with zero-wait memory, done is asserted 2 cycles after the cycle req is first sampled in IDLE. Each memory wait cycle adds 1.
REQ-030 Back-to-back: a request that is still pending is re-arbitrated in the IDLE cycle after RESP. Minimum throughput is one access per 3 cycles.
REQ-031 Write data returns d_rdata=0. Byte/word merging is the memory's responsibility.
REQ-032 i_done and d_done are never high in the same cycle.

Reset
REQ-033 On reset=1, immediately and regardless of clk:
- state=IDLE;
- all done, err and strobe outputs 0;
- mem_addr, mem_wdata, i_rdata, d_rdata = 0;
- mem_mode=2;
- counter=0;
- last_grant=1.
REQ-034 Reset during BUSY or RESP aborts the access; no done pulse is issued for it.
REQ-035 After reset deassertion, the first arbitration occurs on the first rising edge.

Structure
REQ-036 Shared package mem_arb_pkg holds: state enum, port index constants (PORT_I=0, PORT_D=1), MODE_WORD=2.
REQ-037 One sub-module rr_pick2: a combinational 2-way round-robin picker (inputs req[1:0], last; outputs gnt[1:0]). All state lives in mem_arbiter.

Verification
REQ-038 i_req alone, addr 0x100, zero-wait ack, mem_rdata=0xDEADBEEF -> mem_read_en=1 with mem_addr=0x100 and mem_mode=2 one cycle later; i_done=1 with i_rdata=0xDEADBEEF two cycles after the req cycle.
REQ-039 i_req and d_req together twice in a row, after reset -> grant order port0, port1; both requesters held -> grant order port0, port1, port0, port1 with no overlapping done.
REQ-040 d_req write, d_we=1, addr 0x20, wdata 0x12345678, mode 1, ack after 3 cycles -> mem_write_en high for 4 BUSY cycles; d_done at cycle 5 with d_rdata=0, err=0.
REQ-041 TIMEOUT=4, d_req read, mem_ack never -> d_done with err=1 and d_rdata=0 at cycle 6; the next request proceeds normally.
REQ-042 reset pulsed mid-BUSY -> strobes drop asynchronously; no done pulse; after release a held i_req completes normally.
REQ-043 ack on the exact timeout cycle -> done with err=0 and captured data.
